// File: rtl/cdc_xfer_arbiter.sv
// Source-domain scheduler for a toggle-handshake multi-bit CDC channel.
// Round-robin grants one requester at a time; the held word is stable until the ack toggle returns.
module cdc_xfer_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SYNC_STAGE = 2,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          sync_clk,
  input  logic                          sync_rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         xfer_data,
  output logic [ID_WIDTH-1:0]           xfer_src_id,
  output logic                          xfer_req_tgl,
  input  logic                          xfer_ack_tgl_async,
  output logic                          busy,
  output logic                          done,
  output logic                          err_spurious_ack
);

  // state       | meaning
  // ST_IDLE     | free; grant the next valid requester in round-robin order
  // ST_LAUNCH   | word captured; flip the request toggle at the end of this cycle
  // ST_WAIT_ACK | transfer in flight; wait for the synchronized ack toggle
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LAUNCH   = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  state_t                state;
  logic [SYNC_STAGE-1:0] ack_chain;
  logic                  ack_sync;
  logic                  ack_seen;
  logic                  ack_evt;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [ID_WIDTH-1:0]   next_ptr;
  logic                  grant_any;

  always_ff @(posedge sync_clk or negedge sync_rstn) begin
    if (!sync_rstn) begin
      ack_chain <= '0;
    end else begin
      ack_chain <= {ack_chain[SYNC_STAGE-2:0], xfer_ack_tgl_async};
    end
  end

  assign ack_sync = ack_chain[SYNC_STAGE-1];
  assign ack_evt  = ack_sync ^ ack_seen;

  // Walk downward so the requester closest to rr_ptr is written last and wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        grant_any = 1'b1;
        grant_id  = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign next_ptr = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE && grant_any) begin
      req_ready = NUM_REQ'(1) << grant_id;
    end
  end

  always_ff @(posedge sync_clk or negedge sync_rstn) begin
    if (!sync_rstn) begin
      state            <= ST_IDLE;
      ack_seen         <= 1'b0;
      rr_ptr           <= '0;
      xfer_data        <= '0;
      xfer_src_id      <= '0;
      xfer_req_tgl     <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err_spurious_ack <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ack_evt) begin
        ack_seen <= ack_sync;
      end
      case (state)
        ST_IDLE: begin
          if (ack_evt) begin
            err_spurious_ack <= 1'b1;
          end
          if (grant_any) begin
            xfer_data   <= req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
            xfer_src_id <= grant_id;
            rr_ptr      <= next_ptr;
            busy        <= 1'b1;
            state       <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          // An ack here cannot belong to a toggle that has not been launched yet.
          if (ack_evt) begin
            err_spurious_ack <= 1'b1;
          end
          xfer_req_tgl <= ~xfer_req_tgl;
          state        <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (ack_evt) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Self-checking bench for cdc_xfer_arbiter: table vectors, corner sequences and
// randomized transfers against a transaction-level round-robin model.
module tb_cdc_xfer_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SS = 2;
  localparam int IW = 2;

  logic            sync_clk = 1'b0;
  logic            sync_rstn = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   xfer_data;
  logic [IW-1:0]   xfer_src_id;
  logic            xfer_req_tgl;
  logic            ack_async = 1'b0;
  logic            busy;
  logic            done;
  logic            err_spurious_ack;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;

  cdc_xfer_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .SYNC_STAGE(SS), .ID_WIDTH(IW)) dut (
    .sync_clk(sync_clk),
    .sync_rstn(sync_rstn),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .xfer_data(xfer_data),
    .xfer_src_id(xfer_src_id),
    .xfer_req_tgl(xfer_req_tgl),
    .xfer_ack_tgl_async(ack_async),
    .busy(busy),
    .done(done),
    .err_spurious_ack(err_spurious_ack)
  );

  always #5 sync_clk = ~sync_clk;

  typedef struct {
    logic [N-1:0]    v;
    logic [N*DW-1:0] d;
    int              exp_id;
    logic [DW-1:0]   exp_data;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge sync_clk);
    #1;
  endtask

  // Round-robin rule: first valid requester searching upward from the pointer.
  function automatic int model_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic do_xfer(input logic [N-1:0] v, input logic [N*DW-1:0] d, input int g,
                         input logic [DW-1:0] ed, input int ack_dly, input bit scramble);
    logic t0;
    logic t1;
    logic [N-1:0] exp_ready;
    int n;
    t0 = xfer_req_tgl;
    t1 = ~t0;
    exp_ready = '0;
    exp_ready[g] = 1'b1;
    req_valid = v;
    req_data = d;
    #1;
    chk("ready_grant", req_ready, exp_ready);
    chk("busy_idle", busy, 0);
    @(posedge sync_clk);
    #1;
    req_valid = '0;
    chk("xfer_data", xfer_data, ed);
    chk("src_id", xfer_src_id, g);
    chk("busy_launch", busy, 1);
    chk("tgl_hold", xfer_req_tgl, t0);
    chk("ready_launch", req_ready, 0);
    m_ptr = (g + 1) % N;
    tick;
    chk("tgl_flip", xfer_req_tgl, t1);
    if (scramble) begin
      req_data = ~d;
      req_valid = v;
      #1;
      chk("ready_wait", req_ready, 0);
      req_valid = '0;
    end
    repeat (ack_dly) tick;
    chk("data_wait", xfer_data, ed);
    chk("busy_wait", busy, 1);
    ack_async = ~ack_async;
    n = 0;
    while (n < 20) begin
      tick;
      n++;
      if (done) break;
    end
    chk("ack_latency", n, SS + 1);
    chk("busy_done", busy, 0);
    chk("data_hold", xfer_data, ed);
    chk("src_hold", xfer_src_id, g);
    tick;
    chk("done_pulse", done, 0);
    chk("data_idle", xfer_data, ed);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rv;
    logic [N*DW-1:0] rd;
    int g;

    tbl[0] = '{4'b0001, 32'h000000A5, 0, 8'hA5};
    tbl[1] = '{4'b1111, 32'h44332211, 1, 8'h22};
    tbl[2] = '{4'b1111, 32'h44332211, 2, 8'h33};
    tbl[3] = '{4'b1111, 32'h44332211, 3, 8'h44};
    tbl[4] = '{4'b1111, 32'h88776655, 0, 8'h55};
    tbl[5] = '{4'b0101, 32'hDDCCBBAA, 2, 8'hCC};
    tbl[6] = '{4'b0101, 32'hDDCCBBAA, 0, 8'hAA};
    tbl[7] = '{4'b1000, 32'h12000000, 3, 8'h12};
    tbl[8] = '{4'b1000, 32'h34000000, 3, 8'h34};
    tbl[9] = '{4'b0011, 32'h0000F00F, 0, 8'h0F};

    #12;
    chk("rst_data", xfer_data, 0);
    chk("rst_id", xfer_src_id, 0);
    chk("rst_tgl", xfer_req_tgl, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_spurious_ack, 0);
    sync_rstn = 1'b1;
    tick;

    chk("idle_ready", req_ready, 0);
    tick;
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 10; i++) begin
      do_xfer(tbl[i].v, tbl[i].d, tbl[i].exp_id, tbl[i].exp_data, i % 3, i == 2);
    end

    // Ack toggle while idle: sticky error, no done, next transfer unaffected.
    ack_async = ~ack_async;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("spur_no_done", done, 0);
      chk("spur_busy", busy, 0);
    end
    chk("spur_err", err_spurious_ack, 1);
    g = model_grant(4'b0110);
    do_xfer(4'b0110, 32'h00BEEF00, g, (g == 1) ? 8'hEF : 8'hBE, 1, 0);
    chk("spur_sticky", err_spurious_ack, 1);

    // Reset during WAIT_ACK.
    req_valid = 4'b1111;
    req_data = 32'h01020304;
    tick;
    req_valid = '0;
    tick;
    chk("pre_rst_busy", busy, 1);
    sync_rstn = 1'b0;
    ack_async = 1'b0;
    #1;
    chk("mid_rst_data", xfer_data, 0);
    chk("mid_rst_id", xfer_src_id, 0);
    chk("mid_rst_tgl", xfer_req_tgl, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err_spurious_ack, 0);
    chk("mid_rst_ready", req_ready, 0);
    m_ptr = 0;
    tick;
    sync_rstn = 1'b1;
    tick;
    do_xfer(4'b1111, 32'h0A0B0C0D, 0, 8'h0D, 0, 0);

    for (int i = 0; i < 30; i++) begin
      rv = 4'($urandom_range(1, 15));
      rd = $urandom;
      g = model_grant(rv);
      do_xfer(rv, rd, g, rd[g*DW +: DW], $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        req_valid = '0;
        tick;
        chk("rand_idle_ready", req_ready, 0);
        chk("rand_idle_busy", busy, 0);
      end
    end
    chk("final_err", err_spurious_ack, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
